// File: rtl/vanilla_instr_encoder_if.sv
// Request/response bundle for the instruction encoder.
// The request side (v_i .. imm_i) and the output-word side (v_o .. yumi_i) share one interface.
interface vanilla_instr_encoder_if;
  logic        v_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [31:0] imm_i;
  logic        v_o;
  logic [31:0] instr_o;
  logic        err_o;
  logic        yumi_i;

  modport master (
    output v_i, op_i, rd_i, rs1_i, rs2_i, imm_i, yumi_i,
    input  ready_o, v_o, instr_o, err_o
  );

  modport slave (
    input  v_i, op_i, rd_i, rs1_i, rs2_i, imm_i, yumi_i,
    output ready_o, v_o, instr_o, err_o
  );
endinterface

// File: rtl/vanilla_instr_encoder.sv
// Builds RV32 instruction words from structured encode requests.
// LI expands to LUI+ADDI when the immediate does not fit 12 bits signed.
//
// state | meaning
// IDLE  | output register holds nothing, or a final word
// LI_LO | output register holds the LUI word; the ADDI follows on its yumi
module vanilla_instr_encoder (
  input  logic                    clk_i,
  input  logic                    reset_i,
  vanilla_instr_encoder_if.slave  bus
);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_ADDI  = 3'd1;
  localparam logic [2:0] OP_LW    = 3'd2;
  localparam logic [2:0] OP_SW    = 3'd3;
  localparam logic [2:0] OP_BEQ   = 3'd4;
  localparam logic [2:0] OP_JAL   = 3'd5;
  localparam logic [2:0] OP_LI    = 3'd6;
  localparam logic [2:0] OP_FENCE = 3'd7;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [31:0] FENCE_WORD = 32'h0ff0000f;

  typedef enum logic {IDLE, LI_LO} state_t;

  state_t      state_r, state_n;
  logic        v_r, v_n;
  logic [31:0] instr_r, instr_n;
  logic        err_r, err_n;
  logic [11:0] lo_r, lo_n;
  logic [4:0]  rd_r, rd_n;

  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic        fits_i, fits_b, fits_j;
  logic [19:0] li_hi;
  logic [31:0] word;
  logic        word_err;
  logic        two_word;
  logic        ready;
  logic        accept;

  assign imm = bus.imm_i;
  assign rd  = bus.rd_i;
  assign rs1 = bus.rs1_i;
  assign rs2 = bus.rs2_i;

  assign fits_i = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_b = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign fits_j = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

  // (imm + 0x800) >> 12: the carry out of the low 12 bits is exactly imm[11]
  assign li_hi = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    word     = '0;
    word_err = 1'b0;
    two_word = 1'b0;
    case (bus.op_i)
      OP_ADD:  word = {7'b0, rs2, rs1, 3'b000, rd, OPC_OP};
      OP_ADDI: begin
        word     = {imm[11:0], rs1, 3'b000, rd, OPC_IMM};
        word_err = ~fits_i;
      end
      OP_LW: begin
        word     = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
        word_err = ~fits_i;
      end
      OP_SW: begin
        word     = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
        word_err = ~fits_i;
      end
      OP_BEQ: begin
        word     = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
        word_err = ~fits_b;
      end
      OP_JAL: begin
        word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        word_err = ~fits_j;
      end
      OP_LI: begin
        if (fits_i) begin
          word = {imm[11:0], 5'd0, 3'b000, rd, OPC_IMM};
        end else begin
          word     = {li_hi, rd, OPC_LUI};
          two_word = 1'b1;
        end
      end
      OP_FENCE: word = FENCE_WORD;
      default:  word = '0;
    endcase
  end

  assign ready  = (state_r == IDLE) & (~v_r | bus.yumi_i);
  assign accept = bus.v_i & ready;

  always_comb begin
    state_n = state_r;
    v_n     = v_r;
    instr_n = instr_r;
    err_n   = err_r;
    lo_n    = lo_r;
    rd_n    = rd_r;
    if (v_r & bus.yumi_i) v_n = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept) begin
          v_n     = 1'b1;
          instr_n = word;
          err_n   = word_err;
          if (two_word) begin
            state_n = LI_LO;
            lo_n    = imm[11:0];
            rd_n    = rd;
          end
        end
      end
      LI_LO: begin
        if (bus.yumi_i) begin
          v_n     = 1'b1;
          instr_n = {lo_r, rd_r, 3'b000, rd_r, OPC_IMM};
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      v_r     <= 1'b0;
      instr_r <= '0;
      err_r   <= 1'b0;
      lo_r    <= '0;
      rd_r    <= '0;
    end else begin
      state_r <= state_n;
      v_r     <= v_n;
      instr_r <= instr_n;
      err_r   <= err_n;
      lo_r    <= lo_n;
      rd_r    <= rd_n;
    end
  end

  assign bus.ready_o = ready;
  assign bus.v_o     = v_r;
  assign bus.instr_o = instr_r;
  assign bus.err_o   = err_r;

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    bus.yumi_i |-> v_r);

  a_req_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (bus.v_i && !ready) |=> (!bus.v_i ||
      $stable({bus.op_i, bus.rd_i, bus.rs1_i, bus.rs2_i, bus.imm_i})));

endmodule

// File: tb/tb_vanilla_instr_encoder.sv
// Scoreboard bench for vanilla_instr_encoder: directed spec vectors plus
// randomized requests checked against an arithmetic reference model.
module tb_vanilla_instr_encoder;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  vanilla_instr_encoder_if bus ();

  vanilla_instr_encoder dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] w;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   yumi_mode = 1;  // 0 random, 1 always, 2 never

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  task automatic push(input logic [31:0] w, input logic e);
    exp_t x;
    x.w = w;
    x.e = e;
    sb.push_back(x);
  endtask

  // Reference model: range checks on signed integers, fields placed arithmetically.
  task automatic model(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    int          s;
    logic [31:0] d, a, b, hi;
    s = signed'(imm);
    d = 32'(rd);
    a = 32'(rs1);
    b = 32'(rs2);
    case (op)
      3'd0: push((b << 20) + (a << 15) + (d << 7) + 32'h33, 1'b0);
      3'd1: push((fld(imm, 11, 0) << 20) + (a << 15) + (d << 7) + 32'h13,
                 s < -2048 || s > 2047);
      3'd2: push((fld(imm, 11, 0) << 20) + (a << 15) + (32'd2 << 12) + (d << 7) + 32'h03,
                 s < -2048 || s > 2047);
      3'd3: push((fld(imm, 11, 5) << 25) + (b << 20) + (a << 15) + (32'd2 << 12) +
                 (fld(imm, 4, 0) << 7) + 32'h23, s < -2048 || s > 2047);
      3'd4: push((fld(imm, 12, 12) << 31) + (fld(imm, 10, 5) << 25) + (b << 20) + (a << 15) +
                 (fld(imm, 4, 1) << 8) + (fld(imm, 11, 11) << 7) + 32'h63,
                 s < -4096 || s > 4094 || (s % 2) != 0);
      3'd5: push((fld(imm, 20, 20) << 31) + (fld(imm, 10, 1) << 21) + (fld(imm, 11, 11) << 20) +
                 (fld(imm, 19, 12) << 12) + (d << 7) + 32'h6f,
                 s < -1048576 || s > 1048574 || (s % 2) != 0);
      3'd6: begin
        if (s >= -2048 && s <= 2047) begin
          push((fld(imm, 11, 0) << 20) + (d << 7) + 32'h13, 1'b0);
        end else begin
          hi = (imm + 32'h800) >> 12;
          push((hi << 12) + (d << 7) + 32'h37, 1'b0);
          push((fld(imm, 11, 0) << 20) + (d << 15) + (d << 7) + 32'h13, 1'b0);
        end
      end
      default: push(32'h0ff0000f, 1'b0);
    endcase
  endtask

  // Call just after a posedge; returns just after the posedge that accepted the request.
  task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    int cyc = 0;
    bus.op_i  = op;
    bus.rd_i  = rd;
    bus.rs1_i = rs1;
    bus.rs2_i = rs2;
    bus.imm_i = imm;
    bus.v_i   = 1'b1;
    @(negedge clk_i);
    while (!bus.ready_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    if (!bus.ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: ready_o stayed 0 for op %0d", op);
      bus.v_i = 1'b0;
    end
    @(posedge clk_i);
    #1;
    bus.v_i = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  // Consumer
  initial begin
    bus.yumi_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      bus.yumi_i = bus.v_o && !reset_i &&
                   (yumi_mode == 1 || (yumi_mode == 0 && $urandom_range(0, 1) == 1));
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold stability
  initial begin
    logic        hold = 1'b0;
    logic [31:0] hw = '0;
    logic        he = 1'b0;
    exp_t        x;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_v", {31'd0, bus.v_o}, 32'd1);
          chk("hold_instr", bus.instr_o, hw);
          chk("hold_err", {31'd0, bus.err_o}, {31'd0, he});
        end
        if (bus.v_o && bus.yumi_i) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got %h expected none", bus.instr_o);
          end else begin
            x = sb.pop_front();
            chk("instr", bus.instr_o, x.w);
            chk("err", {31'd0, bus.err_o}, {31'd0, x.e});
          end
        end
        hold = bus.v_o && !bus.yumi_i;
        hw   = bus.instr_o;
        he   = bus.err_o;
      end
    end
  end

  initial begin
    logic [31:0] held;
    logic [31:0] imm;
    logic [2:0]  op;
    int          edges[12] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                               1048574, 1048576, -1048576, -1048578};

    bus.v_i = 1'b0;
    bus.op_i = '0;
    bus.rd_i = '0;
    bus.rs1_i = '0;
    bus.rs2_i = '0;
    bus.imm_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("reset_v", {31'd0, bus.v_o}, 32'd0);
    chk("reset_instr", bus.instr_o, 32'd0);
    chk("reset_err", {31'd0, bus.err_o}, 32'd0);
    chk("reset_ready", {31'd0, bus.ready_o}, 32'd1);
    @(posedge clk_i);
    #1;

    yumi_mode = 1;
    push(32'h00100293, 1'b0);
    issue(3'd1, 5'd5, 5'd0, 5'd0, 32'd1);
    chk("addi_latency_v", {31'd0, bus.v_o}, 32'd1);
    chk("addi_latency_w", bus.instr_o, 32'h00100293);
    push(32'h00612423, 1'b0);
    issue(3'd3, 5'd0, 5'd2, 5'd6, 32'd8);
    push(32'h003100b3, 1'b0);
    issue(3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    drain();

    push(32'h12346537, 1'b0);
    push(32'hfff50513, 1'b0);
    issue(3'd6, 5'd10, 5'd0, 5'd0, 32'h12345fff);
    @(negedge clk_i);
    chk("li_lui_word", bus.instr_o, 32'h12346537);
    chk("li_ready_low", {31'd0, bus.ready_o}, 32'd0);
    @(posedge clk_i);
    #1;
    chk("li_no_bubble", {31'd0, bus.v_o}, 32'd1);
    chk("li_addi_word", bus.instr_o, 32'hfff50513);
    drain();

    push(32'hffb00513, 1'b0);
    issue(3'd6, 5'd10, 5'd0, 5'd0, -32'sd5);
    push(32'h00000163, 1'b1);
    issue(3'd4, 5'd0, 5'd0, 5'd0, 32'd3);
    push(32'h8000006f, 1'b1);
    issue(3'd5, 5'd0, 5'd0, 5'd0, 32'h00100000);
    push(32'h0ff0000f, 1'b0);
    issue(3'd7, 5'd0, 5'd0, 5'd0, 32'd0);
    drain();

    yumi_mode = 2;
    push(32'hfff00093, 1'b1);
    issue(3'd1, 5'd1, 5'd0, 5'd0, 32'd4095);
    held = bus.instr_o;
    chk("stall_word", held, 32'hfff00093);
    repeat (5) begin
      @(negedge clk_i);
      chk("stall_instr", bus.instr_o, held);
      chk("stall_err", {31'd0, bus.err_o}, 32'd1);
      chk("stall_ready", {31'd0, bus.ready_o}, 32'd0);
    end
    yumi_mode = 1;
    @(posedge clk_i);
    #1;
    drain();

    yumi_mode = 0;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
        2: imm = $urandom;
        default: imm = 32'(edges[$urandom_range(0, 11)]);
      endcase
      begin
        logic [4:0] rd, rs1, rs2;
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        model(op, rd, rs1, rs2, imm);
        issue(op, rd, rs1, rs2, imm);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
    end
    yumi_mode = 1;
    drain();

    yumi_mode = 2;
    issue(3'd6, 5'd10, 5'd0, 5'd0, 32'h12345fff);
    @(negedge clk_i);
    chk("rst_li_lui", bus.instr_o, 32'h12346537);
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    sb.delete();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    yumi_mode = 1;
    @(negedge clk_i);
    chk("rst_li_v", {31'd0, bus.v_o}, 32'd0);
    chk("rst_li_ready", {31'd0, bus.ready_o}, 32'd1);
    repeat (5) begin
      @(negedge clk_i);
      chk("rst_li_quiet", {31'd0, bus.v_o}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
